uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of payload bits per frame.
REQ-002 SHALL have port clk, input, 1 bit: single clock, one TX bit period per cycle; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA, input, DATA_WIDTH bits: parallel payload.
REQ-005 SHALL have port Data_Valid, input, 1 bit: P_DATA valid this cycle (same strobe that feeds the parity calculator's Valid_Data).
REQ-006 SHALL have port PAR_EN, input, 1 bit: parity bit inserted in frame when 1.
REQ-007 SHALL have port Parity_bit, input, 1 bit: registered parity from the upstream parity calculator.
REQ-008 SHALL have port TX_OUT, output, 1 bit: serial line, registered, idles high.
REQ-009 SHALL have port Busy, output, 1 bit: frame in progress, registered.

Function
REQ-010 SHALL implement a state machine with the states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE with Data_Valid=1, SHALL capture P_DATA and PAR_EN at that edge and go to START; Data_Valid SHALL be ignored in every other state.
REQ-012 In START, SHALL drive TX_OUT=0 and Busy=1 for 1 cycle, latch Parity_bit at the end of the cycle, then go to DATA.
REQ-013 In DATA, SHALL shift out the captured payload LSB first, 1 bit per cycle, for DATA_WIDTH cycles, with the bit counter running 0..DATA_WIDTH-1.
REQ-014 After the last data bit, SHALL go to PARITY if the captured PAR_EN=1, else to STOP.
REQ-015 In PARITY, SHALL drive the Parity_bit value latched in START for 1 cycle; later changes on Parity_bit SHALL NOT affect the frame in flight.
REQ-016 In STOP, SHALL drive TX_OUT=1 for 1 cycle, then go to IDLE.
REQ-017 Busy SHALL be 1 from START through STOP inclusive; frame length SHALL be DATA_WIDTH+2 cycles, or DATA_WIDTH+3 cycles with parity.
REQ-018 In IDLE, TX_OUT SHALL be 1 and Busy SHALL be 0; the minimum gap between frames SHALL be 1 IDLE cycle.
REQ-019 A Data_Valid pulse while Busy=1 SHALL be dropped, with no queuing and no corruption of the current frame.
REQ-020 Latency: TX_OUT start bit SHALL appear on the first edge after the accepting edge.
REQ-021 The bit counter SHALL clear on leaving DATA and SHALL never exceed DATA_WIDTH-1.

Reset
REQ-022 When rst_n=0, the block SHALL immediately set state=IDLE, TX_OUT=1, Busy=0, and shift register, counter and latched parity/enable to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no resumption; the first Data_Valid after release SHALL start a fresh frame.

Structure
REQ-024 Shared package uart_pkg SHALL hold the state enum type, the DATA_WIDTH default and the line-idle constant (1).
REQ-025 The block SHALL contain one sub-module, uart_tx_serializer: load, shift enable, bit counter and done flag; the FSM and output mux SHALL remain in uart_tx_ctrl.

Verification
REQ-026 Bench SHALL check P_DATA=0xA5, PAR_EN=1, Parity_bit=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, Busy high for exactly 11 cycles.
REQ-027 Bench SHALL check P_DATA=0x3C, PAR_EN=0 -> TX_OUT 0,0,0,1,1,1,1,0,0,1 over 10 cycles, with no parity slot.
REQ-028 Bench SHALL check P_DATA=0x07, PAR_EN=1, Parity_bit=1 at START then forced to 0 during DATA -> parity slot = 1.
REQ-029 Bench SHALL check a Data_Valid pulse with P_DATA=0xFF during DATA bit 3 of a 0x00 frame -> frame is all-zero data, no second frame, Busy falls after STOP.
REQ-030 Bench SHALL check rst_n low during DATA bit 4 -> TX_OUT=1 and Busy=0 with no clock edge; after release, Data_Valid with 0x55 -> clean frame.
REQ-031 Bench SHALL check Data_Valid held high continuously -> consecutive frames separated by exactly 1 IDLE cycle with TX_OUT=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: frame FSM states, default payload width, idle line level.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int   DATA_WIDTH_DEF = 8;
    localparam logic LINE_IDLE      = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Parallel-in / serial-out bundle between the payload source and the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: none; Busy tells the source when a Data_Valid strobe would be dropped.
//   master: drives P_DATA, Data_Valid, PAR_EN, Parity_bit; observes TX_OUT, Busy
//   slave : the transmitter side of the same signals
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  Parity_bit;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, Parity_bit,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, Parity_bit,
        output TX_OUT, Busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register plus bit counter; presents the current data bit LSB first.
// Latency: load takes effect at the loading edge; each shift_en edge advances one bit.
// Backpressure: none; the controlling FSM decides when to load and shift.
//   in : load, data (parallel payload), shift_en
//   out: ser_bit (bit currently on offer), done (high during the last data bit)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  shift_en,
    output logic                  ser_bit,
    output logic                  done
);

    localparam int            CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;

    assign ser_bit = shreg[0];
    assign done    = shift_en && (cnt == LAST);

    // Counter wraps to zero on the last bit, so it is already clear when DATA is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= shreg >> 1;
            cnt   <= done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame transmitter: start bit, payload LSB first, optional parity, stop bit.
// Latency: start bit drives the line one edge after the edge that accepts Data_Valid.
// Backpressure: none; Data_Valid outside IDLE is dropped, Busy flags the frame in flight.
//   clk, rst_n : clock (one bit period per cycle), async active-low reset
//   bus        : slave side of uart_tx_ctrl_if (payload in, TX_OUT/Busy out)
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_ctrl_if.slave  bus
);

    tx_state_t state;
    logic      par_en_q;
    logic      par_q;
    logic      tx_q;
    logic      busy_q;
    logic      load;
    logic      shift_en;
    logic      ser_bit;
    logic      done;

    assign load     = (state == IDLE) && bus.Data_Valid;
    assign shift_en = (state == DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data     (bus.P_DATA),
        .shift_en (shift_en),
        .ser_bit  (ser_bit),
        .done     (done)
    );

    // Line and Busy are registered from the current state, so each slot reaches
    // the pins one edge after the state that produces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_q   <= LINE_IDLE;
                    busy_q <= 1'b0;
                    if (bus.Data_Valid) begin
                        par_en_q <= bus.PAR_EN;
                        state    <= START;
                    end
                end
                START: begin
                    tx_q   <= 1'b0;
                    busy_q <= 1'b1;
                    // Upstream parity is registered off the same strobe, so it is
                    // valid here; hold it so later changes cannot touch this frame.
                    par_q  <= bus.Parity_bit;
                    state  <= DATA;
                end
                DATA: begin
                    tx_q   <= ser_bit;
                    busy_q <= 1'b1;
                    if (done) begin
                        state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    tx_q   <= par_q;
                    busy_q <= 1'b1;
                    state  <= STOP;
                end
                STOP: begin
                    tx_q   <= LINE_IDLE;
                    busy_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    tx_q   <= LINE_IDLE;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a driver pushes expected frames into a
// scoreboard queue, a monitor captures each Busy window and compares it.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    frame_t exp_q[$];
    int     n_frames_exp  = 0;
    int     n_frames_seen = 0;
    logic [15:0] last_bits = '0;
    int          last_len  = 0;
    bit          burst_active = 0;
    int          burst_seen   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference frame: start 0, payload LSB first, parity if enabled, stop 1.
    function automatic frame_t model(input logic [DW-1:0] d, input logic pen, input logic pb);
        frame_t f;
        int k;
        f.bits = '0;
        k = 0;
        f.bits[k] = 1'b0; k++;
        for (int i = 0; i < DW; i++) begin
            f.bits[k] = d[i]; k++;
        end
        if (pen) begin
            f.bits[k] = pb; k++;
        end
        f.bits[k] = 1'b1; k++;
        f.len = k;
        return f;
    endfunction

    // ---------------- monitor ----------------
    bit          collecting = 0;
    bit          have_exp   = 0;
    frame_t      cur;
    logic [15:0] got;
    int          n_got = 0;
    int          gap   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            collecting = 0;
            have_exp   = 0;
            n_got      = 0;
            gap        = 0;
        end else if (bus.Busy) begin
            if (!collecting) begin
                collecting = 1;
                n_got = 0;
                got   = '0;
                if (burst_active) begin
                    if (burst_seen > 0) check("burst_gap", 32'(gap), 32'd1);
                    burst_seen++;
                end
                check("frame_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    have_exp = 1;
                end else begin
                    have_exp = 0;
                end
            end
            if (n_got < 16) got[n_got] = bus.TX_OUT;
            n_got++;
        end else begin
            if (collecting) begin
                collecting = 0;
                gap = 1;
                n_frames_seen++;
                last_bits = got;
                last_len  = n_got;
                if (have_exp) begin
                    check("frame_len", 32'(n_got), 32'(cur.len));
                    check("frame_bits", 32'(got & 16'((1 << cur.len) - 1)), 32'(cur.bits));
                end
            end else begin
                gap++;
            end
            check("idle_line", 32'(bus.TX_OUT), 32'd1);
        end
    end

    // ---------------- driver ----------------
    task automatic start_frame(input logic [DW-1:0] d, input logic pen,
                               input logic pb, input logic pb_late);
        @(negedge clk);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.Parity_bit = pb;
        bus.Data_Valid = 1'b1;
        exp_q.push_back(model(d, pen, pb));
        n_frames_exp++;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        check("lat_pre_busy", 32'(bus.Busy), 32'd0);
        check("lat_pre_tx", 32'(bus.TX_OUT), 32'd1);
        @(negedge clk);
        check("lat_start_busy", 32'(bus.Busy), 32'd1);
        check("lat_start_tx", 32'(bus.TX_OUT), 32'd0);
        // Inputs move after capture; the frame in flight must not follow them.
        bus.Parity_bit = pb_late;
        bus.P_DATA     = DW'($urandom);
        bus.PAR_EN     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (bus.Busy !== 1'b0 && c < 40) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("idle_timeout", 32'(c >= 40), 32'd0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pen,
                        input logic pb, input logic pb_late);
        start_frame(d, pen, pb, pb_late);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic          pen;
        logic          pb;

        rst_n          = 1'b0;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.Parity_bit = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(bus.TX_OUT), 32'd1);
        check("reset_busy", 32'(bus.Busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_line", 32'(last_bits), 32'h54A);
        check("a5_busy_len", 32'(last_len), 32'd11);

        send(8'h3C, 1'b0, 1'b1, 1'b1);
        check("3c_line", 32'(last_bits), 32'h278);
        check("3c_busy_len", 32'(last_len), 32'd10);

        send(8'h07, 1'b1, 1'b1, 1'b0);
        check("par_hold", 32'(last_bits[9]), 32'd1);

        // Strobe with 0xFF during data bit 3 of an all-zero frame.
        start_frame(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        bus.P_DATA     = 8'hFF;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        wait_idle();
        check("drop_data", 32'(last_bits[8:1]), 32'h00);
        repeat (15) @(negedge clk);
        check("drop_no_frame", 32'(n_frames_seen), 32'(n_frames_exp));

        // Reset during data bit 4: line must return idle without a clock edge.
        start_frame(8'hC3, 1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(bus.TX_OUT), 32'd1);
        check("abort_busy", 32'(bus.Busy), 32'd0);
        n_frames_exp--;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send(8'h55, 1'b1, 1'b0, 1'b0);
        check("post_rst_data", 32'(last_bits[8:1]), 32'h55);

        // Data_Valid held high: back-to-back frames with a single idle slot.
        d   = DW'($urandom);
        pen = 1'($urandom_range(0, 1));
        pb  = ^d;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model(d, pen, pb));
            n_frames_exp++;
        end
        @(negedge clk);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.Parity_bit = pb;
        burst_seen     = 0;
        burst_active   = 1;
        bus.Data_Valid = 1'b1;
        for (int c = 0; c < 200 && burst_seen < 3; c++) begin
            @(negedge clk);
            #1;
        end
        bus.Data_Valid = 1'b0;
        burst_active   = 0;
        check("burst_count", 32'(burst_seen), 32'd3);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            send(DW'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(n_frames_seen), 32'(n_frames_exp));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
